// File: rtl/data_mem_resp.sv
// Word-addressed, byte-maskable data-memory responder. One request at a time;
// the response comes back LATENCY cycles after acceptance as a one-cycle rvalid pulse.
module data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_valid_i,
  output logic        mem_ready_o,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wmask_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_rvalid_o
);

  localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StRespond} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       resp_q, resp_d;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [29:0]       word_addr;
  logic [AddrW-1:0]  word_idx;
  logic              in_range;
  logic              handshake;
  logic              unused_addr;

  assign word_addr   = mem_addr_i[31:2];
  assign word_idx    = mem_addr_i[2 +: AddrW];
  assign in_range    = ({2'b00, word_addr} < DEPTH_WORDS);
  assign unused_addr = ^mem_addr_i[1:0];

  // Ready depends only on state and reset, never on mem_valid_i.
  assign mem_ready_o  = rst_ni && (state_q == StIdle);
  assign handshake    = mem_valid_i && mem_ready_o;
  assign mem_rvalid_o = rst_ni && (state_q == StRespond);
  assign mem_rdata_o  = mem_rvalid_o ? resp_q : 32'h0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    unique case (state_q)
      StIdle: begin
        if (handshake) begin
          // Read data is the pre-write array value; writes and out-of-range reads answer 0.
          resp_d = ((mem_wmask_i == 4'b0000) && in_range) ? mem_q[word_idx] : 32'h0;
          if (LATENCY == 1) begin
            state_d = StRespond;
          end else begin
            state_d = StBusy;
            cnt_d   = CntW'(LATENCY - 2);
          end
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StRespond;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      resp_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  // Array has no reset; out-of-range writes are dropped.
  always_ff @(posedge clk_i) begin
    if (handshake && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_wmask_i[k]) begin
          mem_q[word_idx][8*k +: 8] <= mem_wdata_i[8*k +: 8];
        end
      end
    end
  end

endmodule
